// File: rtl/zeroriscy_defines.sv
// Shared zero-riscy definitions used by the multi-cycle ALU.
//   - ALU_* operator codes (6-bit encoding shared with the decoder)
//   - alu_mc_state_e : multi-cycle ALU control states
//   - ALU_SHIFT_STEP_DEFAULT : default number of bits shifted per cycle
package zeroriscy_defines;

  localparam int ALU_OP_WIDTH = 6;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 6'b011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 6'b011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 6'b101111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 6'b101110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 6'b010101;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 6'b100100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL   = 6'b100101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL   = 6'b100111;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS   = 6'b000000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU   = 6'b000001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS  = 6'b000010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU  = 6'b000011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LES   = 6'b000100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LEU   = 6'b000101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLETS = 6'b000110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLETU = 6'b000111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GTS   = 6'b001000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GTU   = 6'b001001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES   = 6'b001010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU   = 6'b001011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ    = 6'b001100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE    = 6'b001101;

  localparam int ALU_SHIFT_STEP_DEFAULT = 4;

  typedef enum logic {IDLE, SHIFT} alu_mc_state_e;

  function automatic logic is_shift_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Compares all live in the 0b00xxxx corner of the encoding, but list them
  // explicitly so unused codes there are not mistaken for compares.
  function automatic logic is_cmp_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_LTS)  || (op == ALU_LTU)  || (op == ALU_SLTS)  ||
           (op == ALU_SLTU) || (op == ALU_LES)  || (op == ALU_LEU)   ||
           (op == ALU_SLETS)|| (op == ALU_SLETU)|| (op == ALU_GTS)   ||
           (op == ALU_GTU)  || (op == ALU_GES)  || (op == ALU_GEU)   ||
           (op == ALU_EQ)   || (op == ALU_NE);
  endfunction

endpackage

// File: rtl/zeroriscy_alu_shift_step.sv
// One step of the iterative shifter: shifts data_i by amt_i (0..SHIFT_STEP).
//   data_i : value to shift
//   amt_i  : shift distance for this step
//   dir_i  : 1 = left (zero fill), 0 = right (fill_i fill)
//   fill_i : bit shifted in from the top on right shifts (sign for SRA)
//   data_o : shifted value
module zeroriscy_alu_shift_step #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4,
  parameter int AMT_W      = $clog2(SHIFT_STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             dir_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    if (dir_i) data_o = data_i << amt_i;
    // Right shift of a double-width word whose top half is the fill bit.
    else       data_o = WIDTH'({{WIDTH{fill_i}}, data_i} >> amt_i);
  end

endmodule

// File: rtl/zeroriscy_alu_mc.sv
// Multi-cycle zero-riscy ALU. Add/logic/compare finish in one cycle; shifts
// iterate SHIFT_STEP bits per cycle.
//   clk, rst_n            : clock, async active-low reset
//   enable_i, kill_i      : start request (taken when ready_o), flush
//   operator_i            : ALU operator code
//   operand_a_i/_b_i      : operands; shift amount is b[SHAMT_W-1:0]
//   ready_o               : idle, can accept
//   valid_o               : one-cycle pulse when result registers update
//   result_o, comparison_result_o, adder_result_o : registered results
module zeroriscy_alu_mc
  import zeroriscy_defines::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = ALU_SHIFT_STEP_DEFAULT,
  parameter int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    kill_i,
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [WIDTH-1:0]        operand_a_i,
  input  logic [WIDTH-1:0]        operand_b_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [WIDTH-1:0]        result_o,
  output logic                    comparison_result_o,
  output logic [WIDTH-1:0]        adder_result_o
);

  localparam int AMT_W = $clog2(SHIFT_STEP + 1);

  alu_mc_state_e      state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d, step_out;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, shamt;
  logic               fill_q, fill_d, dir_q, dir_d;
  logic [WIDTH-1:0]   add_pend_q, add_pend_d;
  logic               cmp_pend_q, cmp_pend_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   result_q, result_d, adder_q, adder_d;
  logic               cmp_q, cmp_d;

  // Single-cycle datapath
  logic             is_sub, carry, is_equal, lt_u, lt_s, cmp_result;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] adder_result, alu_result;

  assign shamt = operand_b_i[SHAMT_W-1:0];

  always_comb begin
    is_sub       = (operator_i == ALU_SUB) || is_cmp_op(operator_i);
    sum_w        = {1'b0, operand_a_i}
                 + {1'b0, (is_sub ? ~operand_b_i : operand_b_i)}
                 + {{WIDTH{1'b0}}, is_sub};
    adder_result = sum_w[WIDTH-1:0];
    carry        = sum_w[WIDTH];
    is_equal     = (operand_a_i == operand_b_i);
    // a - b borrows exactly when no carry out of the negated-B add.
    lt_u         = ~carry;
    lt_s         = (operand_a_i[WIDTH-1] != operand_b_i[WIDTH-1]) ?
                   operand_a_i[WIDTH-1] : ~carry;
  end

  always_comb begin
    cmp_result = is_equal;
    case (operator_i)
      ALU_LTS, ALU_SLTS:   cmp_result = lt_s;
      ALU_LTU, ALU_SLTU:   cmp_result = lt_u;
      ALU_LES, ALU_SLETS:  cmp_result = lt_s | is_equal;
      ALU_LEU, ALU_SLETU:  cmp_result = lt_u | is_equal;
      ALU_GTS:             cmp_result = ~(lt_s | is_equal);
      ALU_GTU:             cmp_result = ~(lt_u | is_equal);
      ALU_GES:             cmp_result = ~lt_s;
      ALU_GEU:             cmp_result = ~lt_u;
      ALU_NE:              cmp_result = ~is_equal;
      default:             cmp_result = is_equal;
    endcase
  end

  always_comb begin
    alu_result = '0;
    if (is_cmp_op(operator_i)) alu_result = {{(WIDTH-1){1'b0}}, cmp_result};
    // Only reaches result_o for a zero shift amount.
    else if (is_shift_op(operator_i)) alu_result = operand_a_i;
    else begin
      case (operator_i)
        ALU_ADD, ALU_SUB: alu_result = adder_result;
        ALU_XOR:          alu_result = operand_a_i ^ operand_b_i;
        ALU_OR:           alu_result = operand_a_i | operand_b_i;
        ALU_AND:          alu_result = operand_a_i & operand_b_i;
        default:          alu_result = '0;
      endcase
    end
  end

  // Iterative shifter
  int unsigned      cnt_int, step_int;
  logic [AMT_W-1:0] step;
  logic             last_step;

  always_comb begin
    cnt_int   = 32'(cnt_q);
    step_int  = (cnt_int < SHIFT_STEP) ? cnt_int : SHIFT_STEP;
    step      = AMT_W'(step_int);
    last_step = (cnt_int <= SHIFT_STEP);
  end

  zeroriscy_alu_shift_step #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP),
    .AMT_W      (AMT_W)
  ) u_shift_step (
    .data_i (shift_q),
    .amt_i  (step),
    .dir_i  (dir_q),
    .fill_i (fill_q),
    .data_o (step_out)
  );

  // Control
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    dir_d      = dir_q;
    add_pend_d = add_pend_q;
    cmp_pend_d = cmp_pend_q;
    valid_d    = 1'b0;
    result_d   = result_q;
    cmp_d      = cmp_q;
    adder_d    = adder_q;
    case (state_q)
      IDLE: begin
        if (enable_i && !kill_i) begin
          if (is_shift_op(operator_i) && (shamt != '0)) begin
            shift_d    = operand_a_i;
            cnt_d      = shamt;
            fill_d     = (operator_i == ALU_SRA) & operand_a_i[WIDTH-1];
            dir_d      = (operator_i == ALU_SLL);
            // Side outputs are parked so a killed shift leaves them untouched.
            add_pend_d = adder_result;
            cmp_pend_d = cmp_result;
            state_d    = SHIFT;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_result;
            cmp_d    = cmp_result;
            adder_d  = adder_result;
          end
        end
      end
      SHIFT: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          shift_d = step_out;
          cnt_d   = cnt_q - SHAMT_W'(step_int);
          if (last_step) begin
            valid_d  = 1'b1;
            result_d = step_out;
            cmp_d    = cmp_pend_q;
            adder_d  = add_pend_q;
            state_d  = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      fill_q     <= 1'b0;
      dir_q      <= 1'b0;
      add_pend_q <= '0;
      cmp_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      cmp_q      <= 1'b0;
      adder_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      dir_q      <= dir_d;
      add_pend_q <= add_pend_d;
      cmp_pend_q <= cmp_pend_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      cmp_q      <= cmp_d;
      adder_q    <= adder_d;
    end
  end

  assign ready_o             = (state_q == IDLE);
  assign valid_o             = valid_q;
  assign result_o            = result_q;
  assign comparison_result_o = cmp_q;
  assign adder_result_o      = adder_q;

endmodule

// File: tb/tb_zeroriscy_alu_mc.sv
// Bench for zeroriscy_alu_mc: a per-cycle behavioural model checks the
// 32-bit instance every cycle; directed literals pin the model and the
// 16-bit / single-step instance.
module tb_zeroriscy_alu_mc;
  import zeroriscy_defines::*;

  logic        gclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, kill = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        ready, valid, cmpr;
  logic [31:0] res, addr;

  logic        en16 = 1'b0;
  logic [5:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, valid16, cmpr16;
  logic [15:0] res16, addr16;

  int n_checks = 0, n_fail = 0;

  always #5 gclk = ~gclk;

  zeroriscy_alu_mc dut (
    .clk(gclk), .rst_n(rst_n), .enable_i(en), .kill_i(kill), .operator_i(op),
    .operand_a_i(a), .operand_b_i(b), .ready_o(ready), .valid_o(valid),
    .result_o(res), .comparison_result_o(cmpr), .adder_result_o(addr));

  zeroriscy_alu_mc #(.WIDTH(16), .SHIFT_STEP(1)) dut16 (
    .clk(gclk), .rst_n(rst_n), .enable_i(en16), .kill_i(1'b0), .operator_i(op16),
    .operand_a_i(a16), .operand_b_i(b16), .ready_o(ready16), .valid_o(valid16),
    .result_o(res16), .comparison_result_o(cmpr16), .adder_result_o(addr16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] res;
    logic        cmp;
    logic [31:0] add;
    int          lat;
  } exp_t;

  function automatic exp_t model_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int sh;
    sh = int'(y[4:0]);
    e.add = x + y; e.cmp = (x == y); e.res = '0; e.lat = 1;
    case (o)
      ALU_ADD: e.res = x + y;
      ALU_SUB: begin e.res = x - y; e.add = x - y; end
      ALU_XOR: e.res = x ^ y;
      ALU_OR:  e.res = x | y;
      ALU_AND: e.res = x & y;
      ALU_SLL: e.res = x << sh;
      ALU_SRL: e.res = x >> sh;
      ALU_SRA: e.res = $signed(x) >>> sh;
      default: ;
    endcase
    if ((o == ALU_SLL || o == ALU_SRL || o == ALU_SRA) && sh > 0) e.lat = (sh + 3) / 4 + 1;
    if (is_cmp_op(o)) begin
      e.add = x - y;
      case (o)
        ALU_LTS, ALU_SLTS:  e.cmp = $signed(x) <  $signed(y);
        ALU_LTU, ALU_SLTU:  e.cmp = x <  y;
        ALU_LES, ALU_SLETS: e.cmp = $signed(x) <= $signed(y);
        ALU_LEU, ALU_SLETU: e.cmp = x <= y;
        ALU_GTS:            e.cmp = $signed(x) >  $signed(y);
        ALU_GTU:            e.cmp = x >  y;
        ALU_GES:            e.cmp = $signed(x) >= $signed(y);
        ALU_GEU:            e.cmp = x >= y;
        ALU_EQ:             e.cmp = (x == y);
        default:            e.cmp = (x != y);
      endcase
      e.res = {31'b0, e.cmp};
    end
    return e;
  endfunction

  int          cyc = 0, m_last = 0;
  logic        m_busy = 1'b0, m_valid = 1'b0, m_cmp = 1'b0;
  logic [31:0] m_res = '0, m_add = '0;
  exp_t        m_pend;

  always @(posedge gclk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_res <= '0; m_cmp <= 1'b0; m_add <= '0;
    end else begin
      m_valid <= 1'b0;
      if (m_busy) begin
        if (kill) m_busy <= 1'b0;
        else if (cyc == m_last) begin
          m_busy <= 1'b0; m_valid <= 1'b1;
          m_res <= m_pend.res; m_cmp <= m_pend.cmp; m_add <= m_pend.add;
        end
      end else if (en && !kill) begin
        e = model_op(op, a, b);
        if (e.lat == 1) begin
          m_valid <= 1'b1; m_res <= e.res; m_cmp <= e.cmp; m_add <= e.add;
        end else begin
          m_busy <= 1'b1; m_last <= cyc + e.lat - 1; m_pend <= e;
        end
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge gclk) begin
    check("cyc_valid",  32'(valid), 32'(m_valid));
    check("cyc_ready",  32'(ready), 32'(!m_busy));
    check("cyc_result", res, m_res);
    check("cyc_cmp",    32'(cmpr), 32'(m_cmp));
    check("cyc_adder",  addr, m_add);
  end

  // ---------------- directed stimulus ----------------
  task automatic issue_wait(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int lat);
    op = o; a = x; b = y; en = 1'b1; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge gclk);
      en = 1'b0;
      if (valid) begin lat = i; break; end
    end
  endtask

  task automatic issue16(input logic [5:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int lat);
    op16 = o; a16 = x; b16 = y; en16 = 1'b1; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge gclk);
      en16 = 1'b0;
      if (valid16) begin lat = i; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #22;
    check("rst_result", res, 32'h0);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_adder", addr, 32'h0);
    rst_n = 1'b1;
    @(negedge gclk);

    issue_wait(ALU_ADD, 32'h7FFFFFFF, 32'h1, lat);
    check("add_lat", lat, 1); check("add_res", res, 32'h80000000);
    check("add_adder", addr, 32'h80000000);

    issue_wait(ALU_SRA, 32'h80000000, 32'd31, lat);
    check("sra_lat", lat, 9); check("sra_res", res, 32'hFFFFFFFF);
    issue_wait(ALU_SRL, 32'h80000000, 32'd31, lat);
    check("srl_lat", lat, 9); check("srl_res", res, 32'h00000001);
    issue_wait(ALU_SLL, 32'h1, 32'h0, lat);
    check("sll0_lat", lat, 1); check("sll0_res", res, 32'h00000001);

    issue_wait(ALU_SLTS, 32'hFFFFFFFF, 32'h1, lat);
    check("slts_res", res, 32'h1); check("slts_cmp", 32'(cmpr), 32'h1);
    issue_wait(ALU_SLTU, 32'hFFFFFFFF, 32'h1, lat);
    check("sltu_res", res, 32'h0); check("sltu_cmp", 32'(cmpr), 32'h0);
    issue_wait(ALU_GEU, 32'd5, 32'd5, lat);
    check("geu_res", res, 32'h1);
    issue_wait(ALU_NE, 32'd5, 32'd5, lat);
    check("ne_res", res, 32'h0); check("ne_cmp", 32'(cmpr), 32'h0);

    // kill mid-shift
    op = ALU_SRL; a = 32'hFFFF0000; b = 32'd20; en = 1'b1;
    @(negedge gclk); en = 1'b0;
    @(negedge gclk); kill = 1'b1;
    @(negedge gclk); kill = 1'b0;
    check("kill_ready", 32'(ready), 32'h1);
    check("kill_valid", 32'(valid), 32'h0);
    check("kill_res", res, 32'h0);
    issue_wait(ALU_ADD, 32'd2, 32'd3, lat);
    check("postkill_lat", lat, 1); check("postkill_res", res, 32'd5);

    // enable while busy is ignored
    op = ALU_SLL; a = 32'h0000ABCD; b = 32'd16; en = 1'b1;
    @(negedge gclk); op = ALU_XOR; a = 32'hFF; b = 32'h0F;
    @(negedge gclk); en = 1'b0;
    lat = 0;
    for (int i = 3; i <= 40; i++) begin
      @(negedge gclk);
      if (valid) begin lat = i; break; end
    end
    check("busy_lat", lat, 5); check("busy_res", res, 32'hABCD0000);
    repeat (3) @(negedge gclk);

    // kill on the final shift step
    op = ALU_SRL; a = 32'hF0; b = 32'd4; en = 1'b1;
    @(negedge gclk); en = 1'b0; kill = 1'b1;
    @(negedge gclk); kill = 1'b0;
    check("killlast_valid", 32'(valid), 32'h0);
    check("killlast_res", res, 32'hABCD0000);

    // enable with kill in IDLE
    op = ALU_ADD; a = 32'd1; b = 32'd1; en = 1'b1; kill = 1'b1;
    @(negedge gclk); en = 1'b0; kill = 1'b0;
    check("enkill_valid", 32'(valid), 32'h0);
    check("enkill_res", res, 32'hABCD0000);

    issue_wait(6'b111111, 32'd5, 32'd6, lat);
    check("unk_lat", lat, 1); check("unk_res", res, 32'h0);
    issue_wait(ALU_ADD, 32'd1, 32'd2, lat);
    check("add2_res", res, 32'd3);

    // reset mid-shift
    op = ALU_SRA; a = 32'h80000000; b = 32'd20; en = 1'b1;
    @(negedge gclk); en = 1'b0;
    @(negedge gclk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_res", res, 32'h0);
    check("midrst_adder", addr, 32'h0);
    check("midrst_ready", 32'(ready), 32'h1);
    check("midrst_valid", 32'(valid), 32'h0);
    @(negedge gclk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge gclk);
    check("postrst_valid", 32'(valid), 32'h0);

    // 16-bit, one bit per cycle
    issue16(ALU_SLL, 16'h0001, 16'h0013, lat);
    check("w16_sll_lat", lat, 4); check("w16_sll_res", 32'(res16), 32'h0008);
    issue16(ALU_SUB, 16'h0000, 16'h0001, lat);
    check("w16_sub_lat", lat, 1); check("w16_sub_res", 32'(res16), 32'hFFFF);
    check("w16_sub_adder", 32'(addr16), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
